phy_tx_framer: RTL and testbench

- Transmit-side GMII framer. It is the egress counterpart of the RGMII RX input-delay path.
- Accepts MAC payload bytes on an AXI-stream-style handshake and produces a complete GMII byte stream in the 125 MHz TX domain: preamble, SFD, payload, zero padding, FCS and inter-frame gap.
- Its outputs feed the RGMII TX DDR/ODDR stage.

---
 rtl/phy_tx_framer.sv | 176 +++++++++++++++++
 tb/tb_phy_tx_framer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_framer.sv
// phy_tx_framer: GMII transmit framer. Wraps MAC payload bytes into a
// complete wire frame: preamble, SFD, payload, zero pad, FCS and
// inter-frame gap. Every gmii_* output and status pulse is registered.
module phy_tx_framer #(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned MIN_FRAME    = 60,
   parameter int unsigned IFG_BYTES    = 12
) (
   input  logic       clk_125m,
   input  logic       sys_rst,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   input  logic       s_tlast,
   input  logic       s_tuser,
   output logic       s_tready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       frame_done,
   output logic       underflow
);

   localparam logic [3:0]  PRE_W = 4'(PREAMBLE_LEN);
   localparam logic [15:0] MIN_W = 16'(MIN_FRAME);
   localparam logic [7:0]  IFG_W = 8'(IFG_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   state_t      state, state_n;
   logic [3:0]  pre_cnt, pre_n;
   logic [15:0] byte_cnt, cnt_n, cnt_inc;
   logic [31:0] crc, crc_n;
   logic [1:0]  fcs_idx, fcs_n;
   logic [7:0]  ifg_cnt, ifg_n;
   logic        bad, bad_n;
   logic [7:0]  txd_n;
   logic        en_n, er_n, done_n, uf_n;

   // One byte of reflected CRC-32 (poly 0xEDB88320).
   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   // Payload is only accepted while the state register says DATA.
   assign s_tready = (state == S_DATA);
   assign cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

   // State and output registers; reset returns the wire to idle at once.
   always_ff @(posedge clk_125m) begin
      if (sys_rst) begin
         state      <= S_IDLE;
         pre_cnt    <= '0;
         byte_cnt   <= '0;
         crc        <= '1;
         fcs_idx    <= '0;
         ifg_cnt    <= IFG_W;
         bad        <= 1'b0;
         gmii_txd   <= '0;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         state      <= state_n;
         pre_cnt    <= pre_n;
         byte_cnt   <= cnt_n;
         crc        <= crc_n;
         fcs_idx    <= fcs_n;
         ifg_cnt    <= ifg_n;
         bad        <= bad_n;
         gmii_txd   <= txd_n;
         gmii_tx_en <= en_n;
         gmii_tx_er <= er_n;
         frame_done <= done_n;
         underflow  <= uf_n;
      end
   end

   // Next state plus the byte to drive on the wire after the coming edge.
   // The state names the phase deciding the next byte, so DATA is already
   // active while the SFD is on the wire and the first payload byte follows
   // it without a bubble.
   always_comb begin
      state_n = state;
      pre_n   = pre_cnt;
      cnt_n   = byte_cnt;
      crc_n   = crc;
      fcs_n   = fcs_idx;
      ifg_n   = ifg_cnt;
      bad_n   = bad;
      txd_n   = '0;
      en_n    = 1'b0;
      er_n    = 1'b0;
      done_n  = 1'b0;
      uf_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (s_tvalid) begin
               en_n    = 1'b1;
               txd_n   = 8'h55;
               pre_n   = 4'd1;
               cnt_n   = '0;
               crc_n   = '1;
               bad_n   = 1'b0;
               fcs_n   = '0;
               state_n = (PRE_W == 4'd1) ? S_SFD : S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            en_n  = 1'b1;
            txd_n = 8'h55;
            pre_n = pre_cnt + 4'd1;
            if (pre_cnt + 4'd1 == PRE_W) state_n = S_SFD;
         end
         S_SFD: begin
            en_n    = 1'b1;
            txd_n   = 8'hD5;
            state_n = S_DATA;
         end
         S_DATA: begin
            en_n = 1'b1;
            if (s_tvalid) begin
               txd_n = s_tdata;
               crc_n = crc_next(crc, s_tdata);
               cnt_n = cnt_inc;
               if (s_tlast) begin
                  bad_n   = s_tuser;
                  state_n = (cnt_inc < MIN_W) ? S_PAD : S_FCS;
               end
            end else begin
               er_n    = 1'b1;
               uf_n    = 1'b1;
               ifg_n   = '0;
               state_n = S_IFG;
            end
         end
         S_PAD: begin
            en_n  = 1'b1;
            crc_n = crc_next(crc, 8'h00);
            cnt_n = cnt_inc;
            if (cnt_inc >= MIN_W) state_n = S_FCS;
         end
         S_FCS: begin
            en_n  = 1'b1;
            er_n  = bad;
            txd_n = ~crc[7:0];
            crc_n = crc >> 8;
            fcs_n = fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
               done_n  = 1'b1;
               ifg_n   = '0;
               state_n = S_IFG;
            end
         end
         S_IFG: begin
            ifg_n = ifg_cnt + 8'd1;
            if (ifg_cnt + 8'd1 == IFG_W) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_phy_tx_framer.sv
// Scoreboard bench for phy_tx_framer: dut0 runs without padding, dut1 with
// default parameters. Stimulus pushes expected wire bytes; the monitor pops
// them whenever a DUT drives tx_en/tx_er or a status pulse.
module tb_phy_tx_framer;

   typedef struct {
      int         k;
      logic [7:0] d;
      logic       er;
      logic       done;
      logic       uf;
      int         gap;
      int         len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst    [2];
   logic [7:0] tdata  [2];
   logic       tvalid [2];
   logic       tlast  [2];
   logic       tuser  [2];
   logic       tready [2];
   logic [7:0] txd    [2];
   logic       en     [2];
   logic       er     [2];
   logic       done   [2];
   logic       uf     [2];

   exp_t       q[$];
   logic [7:0] pl[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         idle_run [2];
   int         burst [2];
   logic       started = 1'b0;

   always #4 clk = ~clk;

   phy_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_BYTES(12)) dut0 (
      .clk_125m(clk), .sys_rst(rst[0]), .s_tdata(tdata[0]), .s_tvalid(tvalid[0]),
      .s_tlast(tlast[0]), .s_tuser(tuser[0]), .s_tready(tready[0]), .gmii_txd(txd[0]),
      .gmii_tx_en(en[0]), .gmii_tx_er(er[0]), .frame_done(done[0]), .underflow(uf[0]));

   phy_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12)) dut1 (
      .clk_125m(clk), .sys_rst(rst[1]), .s_tdata(tdata[1]), .s_tvalid(tvalid[1]),
      .s_tlast(tlast[1]), .s_tuser(tuser[1]), .s_tready(tready[1]), .gmii_txd(txd[1]),
      .gmii_tx_en(en[1]), .gmii_tx_er(er[1]), .frame_done(done[1]), .underflow(uf[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic abort_run(input string why);
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", why, $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
   endtask

   task automatic push(input int k, input logic [7:0] d, input logic e, input logic dn,
                       input logic u, input int gap, input int len);
      exp_t x;
      x = '{k: k, d: d, er: e, done: dn, uf: u, gap: gap, len: len};
      q.push_back(x);
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   task automatic fill(input int n, input int seed);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'((i * 7 + seed) & 255));
   endtask

   task automatic push_preamble(input int k, input int gap);
      for (int i = 0; i < 7; i++) push(k, 8'h55, 1'b0, 1'b0, 1'b0, (i == 0) ? gap : -1, -1);
      push(k, 8'hD5, 1'b0, 1'b0, 1'b0, -1, -1);
   endtask

   // Expected wire image of one dut1 frame (padding to 60 bytes).
   task automatic expect_frame(input int k, input int n, input logic bad, input int gap,
                               input int uf_after, input int rst_at);
      logic [31:0] c;
      logic [7:0]  b;
      int          m;
      push_preamble(k, gap);
      if (uf_after >= 0) begin
         for (int i = 0; i < uf_after; i++) push(k, pl[i], 1'b0, 1'b0, 1'b0, -1, -1);
         push(k, 8'h00, 1'b1, 1'b0, 1'b1, -1, -1);
         return;
      end
      if (rst_at >= 0) begin
         for (int i = 0; i < rst_at - 1; i++) push(k, pl[i], 1'b0, 1'b0, 1'b0, -1, -1);
         return;
      end
      m = (n < 60) ? 60 : n;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < m; i++) begin
         b = (i < n) ? pl[i] : 8'h00;
         push(k, b, 1'b0, 1'b0, 1'b0, -1, -1);
         c = crc_upd(c, b);
      end
      c = ~c;
      for (int j = 0; j < 4; j++)
         push(k, c[8*j +: 8], bad, j == 3, 1'b0, -1, (j == 3) ? (8 + m + 4) : -1);
   endtask

   task automatic drive_frame(input int k, input int n, input logic bad,
                              input int uf_after, input int rst_at);
      logic r;
      int   w;
      for (int i = 0; i < n; i++) begin
         if (uf_after >= 0 && i == uf_after) begin
            tvalid[k] = 1'b0;
            tlast[k]  = 1'b0;
            @(posedge clk);
            #1;
            return;
         end
         tdata[k]  = pl[i];
         tvalid[k] = 1'b1;
         tlast[k]  = (i == n - 1);
         tuser[k]  = (i == n - 1) && bad;
         if (rst_at >= 0 && i == rst_at - 1) begin
            rst[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid_txd", txd[k], 0);
            chk("rst_mid_en", en[k], 0);
            chk("rst_mid_er", er[k], 0);
            chk("rst_mid_done", done[k], 0);
            chk("rst_mid_uf", uf[k], 0);
            chk("rst_mid_tready", tready[k], 0);
            tvalid[k] = 1'b0;
            tlast[k]  = 1'b0;
            @(posedge clk);
            #1;
            rst[k] = 1'b0;
            return;
         end
         w = 0;
         do begin
            @(negedge clk);
            r = tready[k];
            @(posedge clk);
            w++;
         end while (!r && w < 300);
         #1;
         if (!r) abort_run("handshake");
      end
      tvalid[k] = 1'b0;
      tlast[k]  = 1'b0;
      tuser[k]  = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      repeat (20) @(negedge clk);
      chk("queue_drained", q.size(), 0);
   endtask

   // Monitor: pops one expected entry per presented wire cycle.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            if (!en[k]) begin
               idle_run[k]++;
               burst[k] = 0;
               chk("tready_idle", tready[k], 0);
            end else begin
               burst[k]++;
            end
            if (en[k] || er[k] || done[k] || uf[k]) begin
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_output: dut%0d txd %0h en %0b er %0b, none expected",
                           k, txd[k], en[k], er[k]);
               end else begin
                  e = q.pop_front();
                  chk("instance", k, e.k);
                  chk("txd", txd[k], e.d);
                  chk("tx_er", er[k], e.er);
                  chk("frame_done", done[k], e.done);
                  chk("underflow", uf[k], e.uf);
                  if (e.gap >= 0) chk("ifg_gap", idle_run[k], e.gap);
                  if (e.len >= 0) chk("tx_en_len", burst[k], e.len);
               end
               if (en[k]) idle_run[k] = 0;
            end
         end
      end
   end

   initial begin
      logic [7:0] fcs0 [4];
      fcs0 = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; tdata[k] = '0; tvalid[k] = 1'b0; tlast[k] = 1'b0; tuser[k] = 1'b0;
         idle_run[k] = 0; burst[k] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_txd", txd[k], 0);
         chk("reset_en", en[k], 0);
         chk("reset_er", er[k], 0);
         chk("reset_done", done[k], 0);
         chk("reset_uf", uf[k], 0);
         chk("reset_tready", tready[k], 0);
      end
      started = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // "123456789" without padding: known CRC CBF43926.
      pl.delete();
      for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
      push_preamble(0, -1);
      for (int i = 0; i < 9; i++) push(0, pl[i], 1'b0, 1'b0, 1'b0, -1, -1);
      for (int j = 0; j < 4; j++) push(0, fcs0[j], 1'b0, j == 3, 1'b0, -1, (j == 3) ? 21 : -1);
      drive_frame(0, 9, 1'b0, -1, -1);
      wait_drain();

      // 1-byte frame padded to 60.
      pl.delete();
      pl.push_back(8'hAB);
      expect_frame(1, 1, 1'b0, -1, -1, -1);
      drive_frame(1, 1, 1'b0, -1, -1);

      // Two back-to-back 64-byte frames.
      for (int f = 0; f < 2; f++) begin
         fill(64, 3 + f * 40);
         expect_frame(1, 64, 1'b0, 12, -1, -1);
         drive_frame(1, 64, 1'b0, -1, -1);
      end

      // Starvation after byte 10 of 64.
      fill(64, 90);
      expect_frame(1, 64, 1'b0, 12, 10, -1);
      drive_frame(1, 64, 1'b0, 10, -1);

      // Bad frame flagged on tlast.
      fill(16, 17);
      expect_frame(1, 16, 1'b1, 12, -1, -1);
      drive_frame(1, 16, 1'b1, -1, -1);

      // Reset during payload byte 20, then a clean frame.
      fill(30, 55);
      expect_frame(1, 30, 1'b0, 12, -1, 20);
      drive_frame(1, 30, 1'b0, -1, 20);
      fill(70, 200);
      expect_frame(1, 70, 1'b0, -1, -1, -1);
      drive_frame(1, 70, 1'b0, -1, -1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
